// File: rtl/serializer_4to1_if.sv
// Word-side and serial-side signals of the 4-to-1 serializer.
// The word source drives din/din_valid and sees din_ready.
// The serial consumer watches d_out/d_out_valid/frame_start/busy.
interface serializer_4to1_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             d_out;
  logic             d_out_valid;
  logic             frame_start;
  logic             busy;

  // Word source plus serial consumer (environment side)
  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  d_out,
    input  d_out_valid,
    input  frame_start,
    input  busy
  );

  // The serializer itself
  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output d_out,
    output d_out_valid,
    output frame_start,
    output busy
  );

endinterface : serializer_4to1_if

// File: rtl/serializer_4to1.sv
// Parallel-to-serial converter feeding the 1-to-4 deserializer.
// It accepts WIDTH-bit words over valid/ready and emits one bit per clock.
// A one-word holding register lets consecutive words stream without gaps.
// The word in the shifter drives d_out directly, so the first bit appears
// in the cycle after the accepting edge.
module serializer_4to1 #(
  parameter int WIDTH     = 4,  // bits per word, must be >= 2
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  serializer_4to1_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,  // shifter empty
    SHIFT = 1'b1   // emitting bits of the word in the shifter
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;

  logic             w_accept;
  logic             w_last;
  logic             w_bit;
  logic [WIDTH-1:0] w_shift_adv;

  // A word transfers on any edge where the source offers one and the
  // holding register has room; din_ready comes straight from a flop.
  assign w_accept = bus.din_valid && !r_hold_full;

  // Final bit of the current word is on d_out this cycle.
  assign w_last = (r_state == SHIFT) && (r_cnt == LAST_BIT);

  // Bit order selection: the outgoing bit sits at one end of the shifter
  // and the word moves toward that end by one position per clock.
  if (MSB_FIRST) begin : g_msb_first
    assign w_bit       = r_shift[WIDTH-1];
    assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_bit       = r_shift[0];
    assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: keep shifting while words keep arriving.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last && !r_hold_full && !w_accept) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: shifter, bit counter and holding register.
  // A held word always enters the shifter before any newer word; a new
  // word can only go straight to the shifter when the hold is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: shifter and hold are cleared so a reset mid-word leaves no
      // stale data that could resurface after release.
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_shift <= bus.din;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_hold_full) begin
              // din_ready was low, so nothing new arrives on this edge
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
            end else if (w_accept) begin
              r_shift <= bus.din;
            end else begin
              r_shift <= '0;
            end
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_shift <= w_shift_adv;
            if (w_accept) begin
              r_hold      <= bus.din;
              r_hold_full <= 1'b1;
            end
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Output decode: everything derives from registers, and d_out is forced
  // low whenever no real bit is being carried.
  always_comb begin
    bus.d_out       = 1'b0;
    bus.d_out_valid = 1'b0;
    bus.frame_start = 1'b0;
    if (r_state == SHIFT) begin
      bus.d_out       = w_bit;
      bus.d_out_valid = 1'b1;
      bus.frame_start = (r_cnt == '0);
    end
    bus.busy      = (r_state == SHIFT) || r_hold_full;
    bus.din_ready = !r_hold_full;
  end

endmodule : serializer_4to1

// File: tb/tb_serializer_4to1.sv
// Directed bench for serializer_4to1: reset, single word, back-to-back
// stream, backpressure, reset mid-word, LSB-first order and a loopback
// through a behavioural 1-to-4 deserializer.
module tb_serializer_4to1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serializer_4to1_if #(.WIDTH(4)) m_if ();
  serializer_4to1_if #(.WIDTH(4)) l_if ();

  serializer_4to1 #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.slave)
  );

  serializer_4to1 #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (l_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural 1-to-4 deserializer on the MSB-first output, aligned by
  // frame_start, assembling MSB-first words.
  logic [3:0] rx_sh = '0;
  int         rx_n  = 0;
  logic [3:0] rx_words [$];

  always @(negedge clk) begin
    logic [3:0] nsh;
    int         nn;
    if (rst_n && m_if.d_out_valid) begin
      if (m_if.frame_start) begin
        nsh = {3'b000, m_if.d_out};
        nn  = 1;
      end else begin
        nsh = {rx_sh[2:0], m_if.d_out};
        nn  = rx_n + 1;
      end
      if (nn == 4) rx_words.push_back(nsh);
      rx_sh <= nsh;
      rx_n  <= nn;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_m(input string tag, input logic d, input logic v, input logic fs);
    check({tag, " d_out"},       32'(m_if.d_out),       32'(d));
    check({tag, " d_out_valid"}, 32'(m_if.d_out_valid), 32'(v));
    check({tag, " frame_start"}, 32'(m_if.frame_start), 32'(fs));
  endtask

  task automatic check_l(input string tag, input logic d, input logic v, input logic fs);
    check({tag, " d_out"},       32'(l_if.d_out),       32'(d));
    check({tag, " d_out_valid"}, 32'(l_if.d_out_valid), 32'(v));
    check({tag, " frame_start"}, 32'(l_if.frame_start), 32'(fs));
  endtask

  // Per-cycle source schedule applied right after each edge of a stream.
  logic [3:0] s_din [12];
  logic       s_vld [12];

  task automatic run_stream(input string tag, input logic [11:0] exp_bits,
                            input logic [11:0] exp_rdy);
    for (int c = 0; c < 12; c++) begin
      tick();
      m_if.din       = s_din[c];
      m_if.din_valid = s_vld[c];
      check_m($sformatf("%s c%0d", tag, c), exp_bits[11-c], 1'b1, (c % 4) == 0);
      check($sformatf("%s c%0d din_ready", tag, c), 32'(m_if.din_ready), 32'(exp_rdy[11-c]));
    end
    tick();
    check_m({tag, " end"}, 1'b0, 1'b0, 1'b0);
    check({tag, " end busy"}, 32'(m_if.busy), 32'(0));
  endtask

  logic [3:0] lb_words [16];
  int         lb_idx;
  int         rx_base;
  logic       acc;

  initial begin
    m_if.din = '0; m_if.din_valid = 1'b0;
    l_if.din = '0; l_if.din_valid = 1'b0;

    // Reset state
    #2;
    check_m("reset", 1'b0, 1'b0, 1'b0);
    check("reset busy",      32'(m_if.busy),      32'(0));
    check("reset din_ready", 32'(m_if.din_ready), 32'(1));
    #8 rst_n = 1'b1;
    tick();

    // Single word 1010, MSB first
    m_if.din = 4'b1010; m_if.din_valid = 1'b1;
    tick();
    m_if.din_valid = 1'b0;
    check_m("single b0", 1'b1, 1'b1, 1'b1);
    tick(); check_m("single b1", 1'b0, 1'b1, 1'b0);
    tick(); check_m("single b2", 1'b1, 1'b1, 1'b0);
    tick(); check_m("single b3", 1'b0, 1'b1, 1'b0);
    tick(); check_m("single idle", 1'b0, 1'b0, 1'b0);
    check("single idle busy", 32'(m_if.busy), 32'(0));

    // Back-to-back C,3,9 with valid held
    s_din = '{4'h3, 4'h9, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    s_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    m_if.din = 4'hC; m_if.din_valid = 1'b1;
    run_stream("stream", 12'b1100_0011_1001, 12'b1000_1000_1111);

    // Backpressure: E,7,6 offered only while din_ready is low
    s_din = '{4'h5, 4'hE, 4'h7, 4'h6, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    s_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    m_if.din = 4'hA; m_if.din_valid = 1'b1;
    run_stream("bp", 12'b1010_0101_1011, 12'b1000_1000_1111);

    // Reset after two bits of F with 5 held
    m_if.din = 4'hF; m_if.din_valid = 1'b1;
    tick();
    m_if.din = 4'h5;
    check_m("rstmid b0", 1'b1, 1'b1, 1'b1);
    tick();
    m_if.din_valid = 1'b0;
    check_m("rstmid b1", 1'b1, 1'b1, 1'b0);
    check("rstmid held", 32'(m_if.din_ready), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    check_m("rstmid async", 1'b0, 1'b0, 1'b0);
    check("rstmid async busy",  32'(m_if.busy),      32'(0));
    check("rstmid async ready", 32'(m_if.din_ready), 32'(1));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("post-rst c%0d valid", c), 32'(m_if.d_out_valid), 32'(0));
      check($sformatf("post-rst c%0d busy", c),  32'(m_if.busy),        32'(0));
    end
    check("post-rst ready", 32'(m_if.din_ready), 32'(1));

    // LSB-first: 0001 -> 1,0,0,0 and 0110 -> 0,1,1,0
    l_if.din = 4'b0001; l_if.din_valid = 1'b1;
    tick();
    l_if.din = 4'b0110;
    check_l("lsb0 b0", 1'b1, 1'b1, 1'b1);
    tick(); l_if.din_valid = 1'b0;
    check_l("lsb0 b1", 1'b0, 1'b1, 1'b0);
    tick(); check_l("lsb0 b2", 1'b0, 1'b1, 1'b0);
    tick(); check_l("lsb0 b3", 1'b0, 1'b1, 1'b0);
    tick(); check_l("lsb1 b0", 1'b0, 1'b1, 1'b1);
    tick(); check_l("lsb1 b1", 1'b1, 1'b1, 1'b0);
    tick(); check_l("lsb1 b2", 1'b1, 1'b1, 1'b0);
    tick(); check_l("lsb1 b3", 1'b0, 1'b1, 1'b0);
    tick(); check_l("lsb idle", 1'b0, 1'b0, 1'b0);

    // Loopback of 16 random nibbles through the deserializer model
    for (int i = 0; i < 16; i++) lb_words[i] = 4'($urandom_range(0, 15));
    rx_base = rx_words.size();
    lb_idx  = 0;
    m_if.din = lb_words[0]; m_if.din_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && lb_idx < 16; cyc++) begin
      acc = m_if.din_valid && m_if.din_ready;
      tick();
      if (acc) begin
        lb_idx++;
        if (lb_idx < 16) m_if.din = lb_words[lb_idx];
        else             m_if.din_valid = 1'b0;
      end
    end
    m_if.din_valid = 1'b0;
    check("lb words sent", 32'(lb_idx), 32'(16));
    for (int cyc = 0; cyc < 40 && m_if.busy; cyc++) tick();
    check("lb drained busy", 32'(m_if.busy), 32'(0));
    check("lb rx count", 32'(rx_words.size() - rx_base), 32'(16));
    for (int i = 0; i < 16; i++) begin
      if (rx_base + i < rx_words.size())
        check($sformatf("lb word %0d", i), 32'(rx_words[rx_base + i]), 32'(lb_words[i]));
      else
        check($sformatf("lb word %0d missing", i), 32'(rx_words.size()), 32'(rx_base + i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serializer_4to1
